// File: rtl/aud_pkg.sv
// Shared AUD trace definitions: state encoding, entry layout and widths.
// Used by aud_trace_ctrl and by the host logic that reads the trace back.
package aud_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned ENTRY_W = 34;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } aud_state_e;

    // Layout of one trace entry, MSB first: {buserror, addr_valid, br_addr}
    typedef struct packed {
        logic              buserror;
        logic              addr_valid;
        logic [ADDR_W-1:0] addr;
    } aud_entry_t;

endpackage

// File: rtl/aud_trace_ram.sv
// Trace storage: DEPTH x WIDTH, one synchronous write port, one synchronous read port.
// Array contents are never reset; only the read data register is.
module aud_trace_ram #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned WIDTH      = 34
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/aud_trace_ctrl.sv
// AUD branch-trace capture controller: circular trace buffer with address trigger,
// post-trigger event count and in-order readout of the captured window.
module aud_trace_ctrl
    import aud_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  aud_ck,
    input  logic                  nrst,
    input  logic [31:0]           br_addr,
    input  logic                  addr_valid,
    input  logic                  oe,
    input  logic                  buserror,
    input  logic                  arm,
    input  logic                  stop,
    input  logic                  trig_en,
    input  logic [31:0]           trig_addr,
    input  logic [31:0]           trig_mask,
    input  logic [DEPTH_LOG2:0]   post_count,
    input  logic                  rd_req,
    output logic [ENTRY_W-1:0]    rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic [1:0]            state,
    output logic                  triggered,
    output logic                  wrapped
);

    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    aud_state_e        state_q, state_n;
    logic              oe_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_n;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [CNT_W-1:0]  unread_q, unread_n;
    logic [CNT_W-1:0]  post_q, post_n;
    logic              trig_q, trig_n;
    logic              wrap_q, wrap_n;
    logic              rd_valid_q, rd_valid_n;
    logic              rd_empty_q, rd_empty_n;

    logic              ev;
    logic              capturing;
    logic              we;
    logic              match;
    logic              hit;
    logic              rd_go;
    aud_entry_t        wr_entry;

    // Event qualification; arm discards a coincident event and blocks reads
    assign ev        = oe & ~oe_q;
    assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign we        = ev & capturing & ~arm;
    assign match     = trig_en & addr_valid & ~|((br_addr ^ trig_addr) & trig_mask);
    assign hit       = we & (state_q == ST_ARMED) & match;
    assign rd_go     = rd_req & ~arm & (state_q == ST_DONE) & (unread_q != '0);
    assign wr_entry  = '{buserror: buserror, addr_valid: addr_valid, addr: br_addr};

    // State register
    always_ff @(posedge aud_ck or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        if (arm) begin
            state_n = ST_ARMED;
        end else begin
            unique case (state_q)
                ST_ARMED: begin
                    if (stop || (hit && (post_count == '0))) begin
                        state_n = ST_DONE;
                    end else if (hit) begin
                        state_n = ST_POST;
                    end
                end
                ST_POST: begin
                    if (stop || (we && (post_q == CNT_W'(1)))) begin
                        state_n = ST_DONE;
                    end
                end
                default: state_n = state_q;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        wr_ptr_n   = wr_ptr_q;
        rd_ptr_n   = rd_ptr_q;
        cnt_n      = cnt_q;
        unread_n   = unread_q;
        post_n     = post_q;
        trig_n     = trig_q;
        wrap_n     = wrap_q;
        rd_valid_n = rd_go;
        if (arm) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            cnt_n    = '0;
            unread_n = '0;
            post_n   = '0;
            trig_n   = 1'b0;
            wrap_n   = 1'b0;
        end else begin
            if (we) begin
                wr_ptr_n = wr_ptr_q + PTR_W'(1);
                if (cnt_q == CNT_W'(DEPTH)) begin
                    wrap_n = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            if (hit) begin
                trig_n = 1'b1;
                post_n = post_count;
            end else if (we && (state_q == ST_POST)) begin
                post_n = post_q - CNT_W'(1);
            end
            // Readout starts at the oldest surviving entry
            if ((state_q != ST_DONE) && (state_n == ST_DONE)) begin
                rd_ptr_n = wr_ptr_n - cnt_n[PTR_W-1:0];
                unread_n = cnt_n;
            end
            if (rd_go) begin
                rd_ptr_n = rd_ptr_q + PTR_W'(1);
                unread_n = unread_q - CNT_W'(1);
            end
        end
        rd_empty_n = !((state_n == ST_DONE) && (unread_n != '0));
    end

    always_ff @(posedge aud_ck or negedge nrst) begin
        if (!nrst) begin
            oe_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            unread_q   <= '0;
            post_q     <= '0;
            trig_q     <= 1'b0;
            wrap_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_empty_q <= 1'b1;
        end else begin
            oe_q       <= oe;
            wr_ptr_q   <= wr_ptr_n;
            rd_ptr_q   <= rd_ptr_n;
            cnt_q      <= cnt_n;
            unread_q   <= unread_n;
            post_q     <= post_n;
            trig_q     <= trig_n;
            wrap_q     <= wrap_n;
            rd_valid_q <= rd_valid_n;
            rd_empty_q <= rd_empty_n;
        end
    end

    // RAM read register doubles as the rd_data output register
    aud_trace_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (ENTRY_W)
    ) u_ram (
        .clk   (aud_ck),
        .rst_n (nrst),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .re    (rd_go),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign state     = state_q;
    assign triggered = trig_q;
    assign wrapped   = wrap_q;
    assign rd_valid  = rd_valid_q;
    assign rd_empty  = rd_empty_q;

endmodule

// File: tb/tb_aud_trace_ctrl.sv
// Bench for aud_trace_ctrl: default-depth and 4-entry instances share stimulus and
// are checked every cycle against a list-based capture model plus literal expectations.
module tb_aud_trace_ctrl;

    logic        aud_ck;
    logic        nrst;
    logic [31:0] br_addr;
    logic        addr_valid;
    logic        oe;
    logic        buserror;
    logic        arm;
    logic        stop;
    logic        trig_en;
    logic [31:0] trig_addr;
    logic [31:0] trig_mask;
    logic [8:0]  post_count;
    logic        rd_req;

    logic [33:0] rdd [2];
    logic        rdv [2];
    logic        rde [2];
    logic [1:0]  st  [2];
    logic        trg [2];
    logic        wrp [2];

    int total = 0;
    int bad   = 0;

    aud_trace_ctrl u_dut0 (
        .aud_ck(aud_ck), .nrst(nrst), .br_addr(br_addr), .addr_valid(addr_valid),
        .oe(oe), .buserror(buserror), .arm(arm), .stop(stop), .trig_en(trig_en),
        .trig_addr(trig_addr), .trig_mask(trig_mask), .post_count(post_count),
        .rd_req(rd_req), .rd_data(rdd[0]), .rd_valid(rdv[0]), .rd_empty(rde[0]),
        .state(st[0]), .triggered(trg[0]), .wrapped(wrp[0])
    );

    aud_trace_ctrl #(.DEPTH_LOG2(2)) u_dut1 (
        .aud_ck(aud_ck), .nrst(nrst), .br_addr(br_addr), .addr_valid(addr_valid),
        .oe(oe), .buserror(buserror), .arm(arm), .stop(stop), .trig_en(trig_en),
        .trig_addr(trig_addr), .trig_mask(trig_mask), .post_count(post_count[2:0]),
        .rd_req(rd_req), .rd_data(rdd[1]), .rd_valid(rdv[1]), .rd_empty(rde[1]),
        .state(st[1]), .triggered(trg[1]), .wrapped(wrp[1])
    );

    initial begin
        aud_ck = 1'b0;
        forever #5 aud_ck = ~aud_ck;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Model: capture log per run; the readable window is the last min(n, depth) entries
    int          dep  [2] = '{256, 4};
    int          mst  [2];
    int          mtrig[2];
    int          mpost[2];
    int          mn   [2];
    int          mri  [2];
    int          mre  [2];
    bit          moe  [2];
    bit          mrv  [2];
    logic [33:0] mrd  [2];
    logic [33:0] mlog [2][64];

    task automatic model_step(input int i);
        bit ev;
        int nst;
        if (!nrst) begin
            mst[i] = 0; mtrig[i] = 0; mpost[i] = 0; mn[i] = 0;
            mri[i] = 0; mre[i] = 0; moe[i] = 0; mrv[i] = 0; mrd[i] = '0;
            return;
        end
        ev     = oe && !moe[i];
        moe[i] = oe;
        mrv[i] = 0;
        if (arm) begin
            mst[i] = 1; mn[i] = 0; mtrig[i] = 0; mri[i] = 0; mre[i] = 0;
            return;
        end
        if (mst[i] == 1 || mst[i] == 2) begin
            nst = mst[i];
            if (ev) begin
                if (mn[i] < 64) mlog[i][mn[i]] = {buserror, addr_valid, br_addr};
                mn[i]++;
                if (mst[i] == 1 && trig_en && addr_valid &&
                    (((br_addr ^ trig_addr) & trig_mask) == 32'h0)) begin
                    mtrig[i] = 1;
                    if (post_count == 9'd0) nst = 3;
                    else begin
                        nst = 2;
                        mpost[i] = int'(post_count);
                    end
                end else if (mst[i] == 2) begin
                    mpost[i]--;
                    if (mpost[i] == 0) nst = 3;
                end
            end
            if (stop) nst = 3;
            if (nst == 3) begin
                mri[i] = (mn[i] > dep[i]) ? mn[i] - dep[i] : 0;
                mre[i] = mn[i];
            end
            mst[i] = nst;
        end else if (mst[i] == 3) begin
            if (rd_req && mri[i] < mre[i]) begin
                mrd[i] = mlog[i][mri[i]];
                mri[i]++;
                mrv[i] = 1;
            end
        end
    endtask

    // Per-cycle compare against the model
    always @(posedge aud_ck) begin
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("state%0d", i), 64'(st[i]), 64'(mst[i]));
            chk($sformatf("triggered%0d", i), 64'(trg[i]), 64'(mtrig[i]));
            chk($sformatf("wrapped%0d", i), 64'(wrp[i]), 64'(mn[i] > dep[i]));
            chk($sformatf("rd_valid%0d", i), 64'(rdv[i]), 64'(mrv[i]));
            chk($sformatf("rd_empty%0d", i), 64'(rde[i]), 64'(!(mst[i] == 3 && mri[i] < mre[i])));
            if (mrv[i]) chk($sformatf("rd_data%0d", i), 64'(rdd[i]), 64'(mrd[i]));
            if (mn[i] > 64) chk($sformatf("model_log_overflow%0d", i), 64'(mn[i]), 64'd64);
        end
    end

    logic [33:0] g0 [8];
    logic [33:0] g1 [8];
    bit          gv0[8];

    task automatic tick();
        @(negedge aud_ck);
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic ev(input logic [31:0] a, input logic av);
        br_addr = a; addr_valid = av; oe = 1'b1;
        tick();
        oe = 1'b0;
        tick();
    endtask

    task automatic rd_burst(input int n);
        rd_req = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            g0[k] = rdd[0]; g1[k] = rdd[1]; gv0[k] = rdv[0];
            if (k == n - 1) rd_req = 1'b0;
        end
    endtask

    logic [33:0] exp25 [4];

    initial begin
        nrst = 1'b1; br_addr = '0; addr_valid = 1'b0; oe = 1'b0; buserror = 1'b0;
        arm = 1'b0; stop = 1'b0; trig_en = 1'b0; trig_addr = '0; trig_mask = '0;
        post_count = '0; rd_req = 1'b0;
        #1 nrst = 1'b0;
        tick(); tick();
        chk("reset_state", 64'(st[0]), 64'd0);
        chk("reset_empty", 64'(rde[0]), 64'd1);
        chk("reset_rd_data", 64'(rdd[1]), 64'd0);
        nrst = 1'b1;
        tick();

        // Events and stop in IDLE are ignored
        ev(32'h999, 1'b1);
        pulse_stop();
        chk("idle_stop", 64'(st[0]), 64'd0);

        // Untriggered capture of five addresses, stop, read back
        pulse_arm();
        for (int k = 0; k < 5; k++) ev(32'h100 + 32'(k), 1'b1);
        pulse_stop();
        chk("c1_done", 64'(st[0]), 64'd3);
        rd_burst(5);
        for (int k = 0; k < 5; k++) chk($sformatf("c1_rd%0d", k), 64'(g0[k]), 64'(34'h1_0000_0100 + 34'(k)));
        chk("c1_empty", 64'(rde[0]), 64'd1);
        for (int k = 0; k < 4; k++) chk($sformatf("c1_small_rd%0d", k), 64'(g1[k]), 64'(34'h1_0000_0101 + 34'(k)));
        rd_burst(1);

        // Wrap in the 4-entry buffer
        pulse_arm();
        for (int k = 0; k < 6; k++) ev(32'hA0 + 32'(k), 1'b1);
        pulse_stop();
        chk("c2_wrapped_small", 64'(wrp[1]), 64'd1);
        chk("c2_wrapped_big", 64'(wrp[0]), 64'd0);
        rd_burst(4);
        for (int k = 0; k < 4; k++) chk($sformatf("c2_small_rd%0d", k), 64'(g1[k]), 64'(34'h1_0000_00A2 + 34'(k)));

        // Masked trigger with two post-trigger events
        trig_en = 1'b1; trig_addr = 32'h8000_1000; trig_mask = 32'hFFFF_F000; post_count = 9'd2;
        pulse_arm();
        ev(32'h10, 1'b1);
        ev(32'h8000_1ABC, 1'b1);
        chk("c3_post", 64'(st[0]), 64'd2);
        ev(32'h20, 1'b1);
        ev(32'h30, 1'b1);
        chk("c3_done", 64'(st[0]), 64'd3);
        chk("c3_trig", 64'(trg[1]), 64'd1);
        ev(32'h40, 1'b1);
        exp25[0] = 34'h1_0000_0010; exp25[1] = 34'h1_8000_1ABC;
        exp25[2] = 34'h1_0000_0020; exp25[3] = 34'h1_0000_0030;
        rd_burst(5);
        for (int k = 0; k < 4; k++) chk($sformatf("c3_rd%0d", k), 64'(g0[k]), 64'(exp25[k]));
        chk("c3_no_fifth", 64'(gv0[4]), 64'd0);

        // addr_valid gates the trigger; post_count 0 ends capture on the trigger
        post_count = 9'd0;
        pulse_arm();
        ev(32'h8000_1ABC, 1'b0);
        chk("c4_no_trig_state", 64'(st[0]), 64'd1);
        chk("c4_no_trig", 64'(trg[0]), 64'd0);
        ev(32'h8000_1ABC, 1'b1);
        chk("c4_done", 64'(st[0]), 64'd3);
        rd_burst(2);
        chk("c4_first", 64'(g0[0]), 64'(34'h0_8000_1ABC));
        chk("c4_last", 64'(g0[1]), 64'(34'h1_8000_1ABC));

        // arm wins over a coincident stop in POST
        post_count = 9'd2;
        pulse_arm();
        ev(32'h8000_1000, 1'b1);
        chk("c5_post", 64'(st[0]), 64'd2);
        arm = 1'b1; stop = 1'b1; oe = 1'b1;
        tick();
        arm = 1'b0; stop = 1'b0; oe = 1'b0;
        chk("c5_armed", 64'(st[0]), 64'd1);
        chk("c5_trig_clr", 64'(trg[0]), 64'd0);
        pulse_stop();
        chk("c5_count0", 64'(rde[0]), 64'd1);

        // Reset in the middle of POST
        pulse_arm();
        ev(32'h8000_1000, 1'b1);
        ev(32'h5, 1'b1);
        nrst = 1'b0;
        #1;
        chk("c6_rst_state", 64'(st[0]), 64'd0);
        chk("c6_rst_empty", 64'(rde[0]), 64'd1);
        chk("c6_rst_trig", 64'(trg[1]), 64'd0);
        tick();
        nrst = 1'b1;
        tick();
        pulse_arm();
        pulse_stop();
        chk("c6_discarded", 64'(rde[0]), 64'd1);

        // Held oe gives one event carrying buserror
        trig_en = 1'b0;
        pulse_arm();
        br_addr = 32'h55; addr_valid = 1'b1; buserror = 1'b1; oe = 1'b1;
        tick(); tick(); tick();
        oe = 1'b0; buserror = 1'b0;
        tick();
        pulse_stop();
        rd_burst(2);
        chk("c7_entry", 64'(g0[0]), 64'(34'h3_0000_0055));
        chk("c7_single", 64'(gv0[1]), 64'd0);
        chk("c7_empty", 64'(rde[0]), 64'd1);

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
